// File: rtl/codec_pkg.sv
// Timing constants and FSM state type for the I2S codec interface.
// All codec clock phases are decoded from one 10-bit frame counter.
package codec_pkg;

   localparam int CNT_W     = 10;
   localparam int MCLK_BIT  = 1;
   localparam int SCLK_BIT  = 4;
   localparam int LRCLK_BIT = 9;

   localparam logic [4:0] RISE_PH = 5'h0F;
   localparam logic [4:0] FALL_PH = 5'h1F;

   localparam logic [CNT_W-1:0] CAPT_CNT  = 10'h00F;
   localparam logic [CNT_W-1:0] VALID_CNT = 10'h010;
   localparam logic [CNT_W-1:0] LOAD_CNT  = 10'h01F;

   typedef enum {RST_HOLD, WARMUP, RUN} codec_state_t;

endpackage

// File: rtl/i2s_shift32.sv
// 32-bit MSB-first shift register with parallel load; load wins over shift.
// q_shift is the word the register would hold after a shift this cycle.
module i2s_shift32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        shift_en,
   input  logic        sin,
   output logic [31:0] q_shift,
   output logic        sout
);

   logic [31:0] q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift_en) begin
         q <= q_shift;
      end
   end

   assign q_shift = {q[30:0], sin};
   assign sout    = q[31];

endmodule

// File: rtl/codec_intf.sv
// I2S codec interface: generates MCLK/SCLK/LRCLK and codec reset from clk,
// deserializes ADC data into lft_in/rht_in and serializes lft_out/rht_out.
module codec_intf
   import codec_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] lft_out,
   input  logic [15:0] rht_out,
   input  logic        RSDin,
   output logic [15:0] lft_in,
   output logic [15:0] rht_in,
   output logic        valid,
   output logic        LRCLK,
   output logic        SCLK,
   output logic        MCLK,
   output logic        RSTn,
   output logic        SDout
);

   logic [CNT_W-1:0] cnt;
   codec_state_t     state;
   codec_state_t     state_nxt;
   logic             rise_ev;
   logic             fall_ev;
   logic             capt;
   logic             tx_load;
   logic             wrap;
   logic             vld_en;
   logic             vld_p1;
   logic [31:0]      rx_word;
   logic [31:0]      tx_word_unused;
   logic             rx_sout_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Codec clocks come straight from counter flops, so they are glitch-free.
   assign MCLK  = cnt[MCLK_BIT];
   assign SCLK  = cnt[SCLK_BIT];
   assign LRCLK = cnt[LRCLK_BIT];

   assign rise_ev = (cnt[4:0] == RISE_PH);
   assign fall_ev = (cnt[4:0] == FALL_PH);
   assign capt    = (cnt == CAPT_CNT);
   assign tx_load = (cnt == LOAD_CNT);
   assign wrap    = (cnt == {CNT_W{1'b1}});

   i2s_shift32 u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (1'b0),
      .load_val (32'h0),
      .shift_en (rise_ev),
      .sin      (RSDin),
      .q_shift  (rx_word),
      .sout     (rx_sout_unused)
   );

   // The load at LOAD_CNT coincides with a fall event and takes priority.
   i2s_shift32 u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tx_load),
      .load_val ({lft_out, rht_out}),
      .shift_en (fall_ev),
      .sin      (1'b0),
      .q_shift  (tx_word_unused),
      .sout     (SDout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RST_HOLD: if (wrap) state_nxt = WARMUP;
         WARMUP:   if (wrap) state_nxt = RUN;
         RUN:      state_nxt = RUN;
         default:  state_nxt = RST_HOLD;
      endcase
   end

   always_comb begin
      RSTn   = 1'b0;
      vld_en = 1'b0;
      case (state)
         RST_HOLD: begin
            RSTn   = 1'b0;
            vld_en = 1'b0;
         end
         WARMUP: begin
            RSTn   = 1'b1;
            vld_en = 1'b0;
         end
         RUN: begin
            RSTn   = 1'b1;
            vld_en = 1'b1;
         end
         default: begin
            RSTn   = 1'b0;
            vld_en = 1'b0;
         end
      endcase
   end

   // Stage p1: capture includes the right-channel LSB shifted in this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         lft_in <= '0;
         rht_in <= '0;
      end else begin
         vld_p1 <= capt & vld_en;
         if (capt) begin
            lft_in <= rx_word[31:16];
            rht_in <= rx_word[15:0];
         end
      end
   end

   assign valid = vld_p1;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: an I2S codec model feeds RSDin, and
// expected timing is computed from cycle counts since reset release.
module tb_codec_intf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] lft_out = 16'h0;
   logic [15:0] rht_out = 16'h0;
   logic        RSDin;
   logic [15:0] lft_in;
   logic [15:0] rht_in;
   logic        valid;
   logic        LRCLK;
   logic        SCLK;
   logic        MCLK;
   logic        RSTn;
   logic        SDout;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic        loop_en = 1'b0;
   logic [31:0] codec_word = 32'h0;

   codec_intf dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .lft_out (lft_out),
      .rht_out (rht_out),
      .RSDin   (RSDin),
      .lft_in  (lft_in),
      .rht_in  (rht_in),
      .valid   (valid),
      .LRCLK   (LRCLK),
      .SCLK    (SCLK),
      .MCLK    (MCLK),
      .RSTn    (RSTn),
      .SDout   (SDout)
   );

   always #10 clk = ~clk;

   // Cycle index since reset release; cycle 0 is the one right after release.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // I2S codec: word MSB goes out in the SCLK period after the LRCLK edge,
   // the final LSB lands in period 0 of the following frame.
   function automatic logic codec_bit(input int c, input logic [31:0] w);
      int         s;
      logic [4:0] idx;
      s   = (c % 1024) / 32;
      idx = 5'(32 - s);
      return w[idx];
   endfunction

   assign RSDin = loop_en ? SDout : codec_bit(cyc, codec_word);

   task automatic wait_ph(input int target);
      int k;
      k = 0;
      @(negedge clk);
      while ((cyc % 1024) != target && k < 2100) begin
         @(negedge clk);
         k++;
      end
      if ((cyc % 1024) != target) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_ph timeout: phase %0d want %0d", cyc % 1024, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      codec_word = 32'hA5C3_3C5A;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({MCLK, SCLK, LRCLK, SDout, RSTn, valid} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000", {MCLK, SCLK, LRCLK, SDout, RSTn, valid});
      end
      n_cmp++;
      if (lft_in !== 16'h0) begin
         n_err++;
         $display("FAIL reset_lft_in: got %h want 0000", lft_in);
      end
      n_cmp++;
      if (rht_in !== 16'h0) begin
         n_err++;
         $display("FAIL reset_rht_in: got %h want 0000", rht_in);
      end
      rst_n = 1'b1;
   endtask

   // Runs from release (cycle 0) up to cycle 2064: codec reset, clocks, no valid.
   task automatic test_hold_and_clocks();
      logic [2:0] exp_clk;
      logic       exp_rstn;
      int         guard;
      guard = 0;
      while (cyc < 2064 && guard < 3000) begin
         exp_clk[2] = ((cyc / 2) % 2) == 1;
         exp_clk[1] = ((cyc / 16) % 2) == 1;
         exp_clk[0] = ((cyc / 512) % 2) == 1;
         exp_rstn   = (cyc >= 1024);
         n_cmp++;
         if ({MCLK, SCLK, LRCLK} !== exp_clk) begin
            n_err++;
            $display("FAIL clocks cyc=%0d: got %b want %b", cyc, {MCLK, SCLK, LRCLK}, exp_clk);
         end
         n_cmp++;
         if (RSTn !== exp_rstn) begin
            n_err++;
            $display("FAIL codec_rstn cyc=%0d: got %b want %b", cyc, RSTn, exp_rstn);
         end
         n_cmp++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid cyc=%0d: got %b want 0", cyc, valid);
         end
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (cyc != 2064) begin
         n_err++;
         $display("FAIL hold_timeout: cyc %0d want 2064", cyc);
      end
   endtask

   task automatic test_receive();
      logic [31:0] exp;
      exp = 32'hA5C3_3C5A;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL rx_valid frame %0d: got %b want 1", i, valid);
         end
         n_cmp++;
         if ({lft_in, rht_in} !== exp) begin
            n_err++;
            $display("FAIL rx_data frame %0d: got %h want %h", i, {lft_in, rht_in}, exp);
         end
         codec_word = $urandom;
         exp = codec_word;
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_valid_width frame %0d: got %b want 0", i, valid);
         end
         if (i < 3) wait_ph(16);
      end
   endtask

   task automatic test_transmit();
      logic [31:0] exp;
      logic [31:0] got;
      for (int t = 0; t < 3; t++) begin
         wait_ph(16);
         if (t == 0) exp = 32'h8001_7FFE;
         else        exp = $urandom;
         lft_out = exp[31:16];
         rht_out = exp[15:0];
         got = 32'h0;
         for (int k = 0; k < 31; k++) begin
            wait_ph(16'h2F + 32 * k);
            got = {got[30:0], SDout};
            if (k == 6) begin
               lft_out = 16'($urandom);
               rht_out = 16'($urandom);
            end
         end
         wait_ph(16'h0F);
         n_cmp++;
         if (SDout !== exp[0]) begin
            n_err++;
            $display("FAIL tx_lsb_next_frame %0d: got %b want %b", t, SDout, exp[0]);
         end
         got = {got[30:0], SDout};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL tx_word %0d: got %h want %h", t, got, exp);
         end
      end
   endtask

   task automatic test_loopback();
      logic [31:0] sent[$];
      logic [31:0] v;
      logic [31:0] exp;
      wait_ph(16);
      loop_en = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            wait_ph(16);
            exp = sent.pop_front();
            n_cmp++;
            if (valid !== 1'b1) begin
               n_err++;
               $display("FAIL loop_valid %0d: got %b want 1", i, valid);
            end
            n_cmp++;
            if ({lft_in, rht_in} !== exp) begin
               n_err++;
               $display("FAIL loop_data %0d: got %h want %h", i, {lft_in, rht_in}, exp);
            end
         end
         v = $urandom;
         sent.push_back(v);
         lft_out = v[31:16];
         rht_out = v[15:0];
      end
      loop_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      int          guard;
      w = $urandom;
      codec_word = w;
      wait_ph(16'h150);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({MCLK, SCLK, LRCLK, SDout, RSTn, valid} !== 6'b0) begin
         n_err++;
         $display("FAIL midreset_ctrl: got %b want 000000", {MCLK, SCLK, LRCLK, SDout, RSTn, valid});
      end
      n_cmp++;
      if ({lft_in, rht_in} !== 32'h0) begin
         n_err++;
         $display("FAIL midreset_data: got %h want 00000000", {lft_in, rht_in});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      guard = 0;
      while (cyc < 2064 && guard < 3000) begin
         n_cmp++;
         if (RSTn !== (cyc >= 1024)) begin
            n_err++;
            $display("FAIL midreset_rstn cyc=%0d: got %b want %b", cyc, RSTn, cyc >= 1024);
         end
         n_cmp++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_early_valid cyc=%0d: got %b want 0", cyc, valid);
         end
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (valid !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_first_valid cyc=%0d: got %b want 1", cyc, valid);
      end
      n_cmp++;
      if ({lft_in, rht_in} !== w) begin
         n_err++;
         $display("FAIL midreset_data_after: got %h want %h", {lft_in, rht_in}, w);
      end
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_valid_width: got %b want 0", valid);
      end
   endtask

   initial begin
      test_reset();
      test_hold_and_clocks();
      test_receive();
      test_transmit();
      test_loopback();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
